// File: rtl/gpio_capture.sv
// gpio_capture: input-side companion to the GPIO driver.
// Synchronizes one asynchronous GPIO line, debounces it, flags debounced
// rising/falling edges, and measures how many clock cycles each debounced
// level lasts. Every completed segment is reported on a valid/ready port.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_gpio            asynchronous GPIO input
//   i_enable          measurement enable (sync/debounce/edges always run)
//   o_level           debounced level
//   o_rise, o_fall    one-cycle debounced edge pulses
//   o_width           cycles the reported segment lasted (saturating)
//   o_width_level     level of the reported segment (1 = high pulse)
//   o_valid, i_ready  result handshake
//   o_overflow        sticky flag: a result was dropped under backpressure
//   i_clr_ovf         clears o_overflow (a simultaneous set wins)
module gpio_capture #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_gpio,
    input  logic             i_enable,
    output logic             o_level,
    output logic             o_rise,
    output logic             o_fall,
    output logic [CNT_W-1:0] o_width,
    output logic             o_width_level,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_overflow,
    input  logic             i_clr_ovf
);

    localparam int unsigned      DW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DW-1:0]    DCNT_MAX = DW'(DEBOUNCE - 1);
    localparam logic [DW-1:0]    DCNT_ONE = DW'(1);
    localparam logic [CNT_W-1:0] WCNT_MAX = '1;
    localparam logic [CNT_W-1:0] WCNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sy;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic                   level_q, level_d;
    logic                   flip;
    logic                   rise_q, fall_q;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       wcnt_q, wcnt_d;
    logic                   emit;
    logic                   valid_q, valid_d;
    logic [CNT_W-1:0]       width_q, width_d;
    logic                   wlvl_q, wlvl_d;
    logic                   ovf_q, ovf_d;

    assign sy = sync_q[SYNC_STAGES-1];

    // Debounce: flip the level once DEBOUNCE consecutive samples disagree.
    always_comb begin
        dcnt_d = dcnt_q;
        flip   = 1'b0;
        if (sy == level_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_MAX) begin
            flip   = 1'b1;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + DCNT_ONE;
        end
        level_d = level_q ^ flip;
    end

    // Measurement FSM. flip is the debounced edge seen at the same clock
    // edge that updates o_level, so results carry zero extra latency.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        emit    = 1'b0;
        if (!i_enable) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (flip) begin
                        state_d = ST_MEASURE;
                        wcnt_d  = WCNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    if (flip) begin
                        emit   = 1'b1;
                        wcnt_d = WCNT_ONE;
                    end else if (wcnt_q != WCNT_MAX) begin
                        wcnt_d = wcnt_q + WCNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Result port: a held result is never overwritten; a new one is dropped.
    always_comb begin
        valid_d = valid_q;
        width_d = width_q;
        wlvl_d  = wlvl_q;
        ovf_d   = ovf_q;
        if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (emit) begin
            if (!valid_q || i_ready) begin
                valid_d = 1'b1;
                width_d = wcnt_q;
                wlvl_d  = level_q;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '0;
            dcnt_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
            width_q <= '0;
            wlvl_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_gpio};
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
            rise_q  <= flip & ~level_q;
            fall_q  <= flip & level_q;
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            valid_q <= valid_d;
            width_q <= width_d;
            wlvl_q  <= wlvl_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_level       = level_q;
    assign o_rise        = rise_q;
    assign o_fall        = fall_q;
    assign o_width       = width_q;
    assign o_width_level = wlvl_q;
    assign o_valid       = valid_q;
    assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_gpio_capture.sv
// Self-checking bench for gpio_capture: a timestamp-based behavioural model
// runs alongside a default instance and a narrow-counter (CNT_W=4) instance.
module tb_gpio_capture;

    localparam int S = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, gpio, en, ready, clr;

    logic        o_level, o_rise, o_fall, o_wl, o_valid, o_ovf;
    logic [15:0] o_width;
    logic        b_level, b_rise, b_fall, b_wl, b_valid, b_ovf;
    logic [3:0]  b_width;

    gpio_capture #(.SYNC_STAGES(S), .DEBOUNCE(D), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_gpio(gpio), .i_enable(en),
        .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
        .o_width(o_width), .o_width_level(o_wl), .o_valid(o_valid),
        .i_ready(ready), .o_overflow(o_ovf), .i_clr_ovf(clr)
    );

    gpio_capture #(.SYNC_STAGES(S), .DEBOUNCE(D), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_gpio(gpio), .i_enable(en),
        .o_level(b_level), .o_rise(b_rise), .o_fall(b_fall),
        .o_width(b_width), .o_width_level(b_wl), .o_valid(b_valid),
        .i_ready(ready), .o_overflow(b_ovf), .i_clr_ovf(clr)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // sy is i_gpio delayed S edges; the level flips when the last D sy
    // samples all disagree with it; a width is the distance in cycles
    // between two consecutive edges seen while measurement is armed.
    bit sq[S];
    bit win[D];
    bit m_level, m_rise, m_fall, m_valid, m_wl, m_ovf;
    bit prev_en, seg_ok;
    int cyc, seg_start, m_raw;
    bit s_v, fl, emit, drop;
    int raw;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            foreach (sq[i]) sq[i] = 1'b0;
            foreach (win[i]) win[i] = 1'b0;
            m_level = 0; m_rise = 0; m_fall = 0; m_valid = 0; m_wl = 0; m_ovf = 0;
            prev_en = 0; seg_ok = 0; m_raw = 0;
        end else begin
            s_v = sq[S-1];
            for (int i = S - 1; i > 0; i--) sq[i] = sq[i-1];
            sq[0] = gpio;
            for (int i = D - 1; i > 0; i--) win[i] = win[i-1];
            win[0] = s_v;
            fl = 1'b1;
            foreach (win[i]) if (win[i] == m_level) fl = 1'b0;
            emit = 1'b0;
            raw  = 0;
            if (fl && en && prev_en) begin
                if (seg_ok) begin
                    emit = 1'b1;
                    raw  = cyc - seg_start;
                end
                seg_start = cyc;
                seg_ok    = 1'b1;
            end
            if (!en) seg_ok = 1'b0;
            prev_en = en;
            m_rise = fl && !m_level;
            m_fall = fl && m_level;
            drop = emit && m_valid && !ready;
            if (emit) begin
                if (!m_valid || ready) begin
                    m_raw = raw; m_wl = m_level; m_valid = 1'b1;
                end
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (fl) m_level = !m_level;
        end
    end

    typedef struct {int w; int w4; bit l;} res_t;
    res_t log_q[$];

    // Per-cycle compare, plus a log of accepted results for directed checks.
    always @(posedge clk) begin
        #1;
        check("level", 32'(o_level), 32'(m_level));
        check("rise",  32'(o_rise),  32'(m_rise));
        check("fall",  32'(o_fall),  32'(m_fall));
        check("valid", 32'(o_valid), 32'(m_valid));
        check("ovf",   32'(o_ovf),   32'(m_ovf));
        check("wlvl",  32'(o_wl),    32'(m_wl));
        check("width", 32'(o_width), (m_raw > 65535) ? 32'd65535 : 32'(m_raw));
        check("width4", 32'(b_width), (m_raw > 15) ? 32'd15 : 32'(m_raw));
        check("valid4", 32'(b_valid), 32'(m_valid));
        if (!rst && o_valid && ready)
            log_q.push_back('{w: int'(o_width), w4: int'(b_width), l: o_wl});
    end

    // ---------------- stimulus ----------------
    bit saw;

    initial begin
        rst = 1'b1; gpio = 1'b1; en = 1'b0; ready = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", 32'(o_level), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_width", 32'(o_width), 0);
        check("rst_ovf",   32'(o_ovf),   0);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_lvl_e4", 32'(o_level), 0);
        @(posedge clk); #1;
        check("rst_lvl_e5",  32'(o_level), 1);
        check("rst_rise_e5", 32'(o_rise),  1);
        check("rst_noval",   32'(o_valid), 0);
        @(posedge clk); #1;
        check("rst_rise_e6", 32'(o_rise), 0);

        // Glitch rejection
        @(negedge clk); gpio = 1'b0;
        repeat (12) @(negedge clk);
        en = 1'b1; ready = 1'b1;
        repeat (4) @(negedge clk);
        gpio = 1'b1;
        repeat (3) @(negedge clk);
        gpio = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (o_level || o_rise || o_valid) saw = 1'b1;
        end
        check("glitch_seen", 32'(saw), 0);

        // Pulse measurement
        log_q.delete();
        @(negedge clk); gpio = 1'b1;
        repeat (20) @(negedge clk);
        gpio = 1'b0;
        repeat (35) @(negedge clk);
        gpio = 1'b1;
        repeat (12) @(negedge clk);
        check("pulse_cnt", 32'(log_q.size()), 2);
        if (log_q.size() == 2) begin
            check("pulse_w0", 32'(log_q[0].w), 20);
            check("pulse_l0", 32'(log_q[0].l), 1);
            check("pulse_w1", 32'(log_q[1].w), 35);
            check("pulse_l1", 32'(log_q[1].l), 0);
        end

        // Backpressure
        gpio = 1'b0;
        repeat (15) @(negedge clk);
        gpio = 1'b1;
        repeat (8) @(negedge clk);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        gpio = 1'b0;
        repeat (12) @(negedge clk);
        gpio = 1'b1;
        repeat (8) @(negedge clk);
        check("bp_valid", 32'(o_valid), 1);
        check("bp_width", 32'(o_width), 10);
        check("bp_wlvl",  32'(o_wl),    1);
        check("bp_ovf",   32'(o_ovf),   1);
        ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drain", 32'(o_valid), 0);
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1;
        check("bp_clr", 32'(o_ovf), 0);
        @(negedge clk); clr = 1'b0;

        // Saturation on the CNT_W=4 instance
        log_q.delete();
        gpio = 1'b0;
        repeat (10) @(negedge clk);
        gpio = 1'b1;
        repeat (40) @(negedge clk);
        gpio = 1'b0;
        repeat (10) @(negedge clk);
        check("sat_cnt", 32'(log_q.size()), 3);
        if (log_q.size() == 3) begin
            check("sat_low_w",  32'(log_q[1].w4), 10);
            check("sat_low_l",  32'(log_q[1].l),  0);
            check("sat_w16",    32'(log_q[2].w),  40);
            check("sat_w4",     32'(log_q[2].w4), 15);
            check("sat_l",      32'(log_q[2].l),  1);
        end

        // Disable mid-segment
        gpio = 1'b1;
        repeat (14) @(negedge clk);
        log_q.delete();
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (4) @(negedge clk);
        gpio = 1'b0;
        repeat (9) @(negedge clk);
        gpio = 1'b1;
        repeat (10) @(negedge clk);
        check("dis_cnt", 32'(log_q.size()), 1);
        if (log_q.size() == 1) begin
            check("dis_w", 32'(log_q[0].w), 9);
            check("dis_l", 32'(log_q[0].l), 0);
        end

        // Randomized phase
        for (int seg = 0; seg < 400; seg++) begin
            int run;
            run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D) : $urandom_range(D, 30);
            gpio = ~gpio;
            for (int c = 0; c < run; c++) begin
                ready = ($urandom_range(0, 9) < 7);
                clr   = ($urandom_range(0, 19) == 0);
                if (en) begin
                    if ($urandom_range(0, 99) < 2) en = 1'b0;
                end else if ($urandom_range(0, 4) == 0) begin
                    en = 1'b1;
                end
                rst = ($urandom_range(0, 499) == 0);
                @(negedge clk);
            end
        end
        rst = 1'b0; clr = 1'b0;
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
